// File: rtl/adc_spi_responder.sv
// adc_spi_responder: SPI slave emulating a serial ADC.
// Returns queued sample words MSB-first after LEAD_BITS zeros.
module adc_spi_responder #(
  parameter int NUMBER_OF_BITS = 8,
  parameter int LEAD_BITS      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cs_n,
  input  logic                      sclk,
  output logic                      miso,
  input  logic [NUMBER_OF_BITS-1:0] tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      frame_abort,
  output logic                      underrun
);

  localparam int FRAME_BITS = LEAD_BITS + NUMBER_OF_BITS;
  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_BITS);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t state_q, state_d;

  logic [2:0] cs_sr, sclk_sr;
  logic       cs_fall, cs_rise;
  logic       sclk_fall, sclk_rise;

  logic [NUMBER_OF_BITS-1:0] hold_q, last_q, word;
  logic                      full_q, push;
  logic [FRAME_BITS-1:0]     shreg_q;
  logic [CW-1:0]             cnt_q, rise_q;

  logic start, shift, rise, finish;
  logic done_d, abort_d;

  // [0],[1] form the synchroniser, [2] is the previous value for edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sr   <= 3'b111;
      sclk_sr <= 3'b000;
    end else begin
      cs_sr   <= {cs_sr[1:0], cs_n};
      sclk_sr <= {sclk_sr[1:0], sclk};
    end
  end

  assign cs_fall   = cs_sr[2] & ~cs_sr[1];
  assign cs_rise   = ~cs_sr[2] & cs_sr[1];
  assign sclk_fall = sclk_sr[2] & ~sclk_sr[1];
  assign sclk_rise = ~sclk_sr[2] & sclk_sr[1];

  assign push     = tx_valid & ~full_q;
  assign word     = full_q ? hold_q : last_q;
  assign tx_ready = ~full_q;
  assign busy     = (state_q == SHIFT);
  assign miso     = shreg_q[FRAME_BITS-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    shift   = 1'b0;
    rise    = 1'b0;
    finish  = 1'b0;
    done_d  = 1'b0;
    abort_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          start   = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // chip-select release takes priority over any clock edge
        if (cs_rise) begin
          finish  = 1'b1;
          state_d = IDLE;
          if (rise_q == LAST) done_d  = 1'b1;
          else                abort_d = 1'b1;
        end else if (sclk_fall) begin
          shift = 1'b1;
        end else if (sclk_rise) begin
          rise = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q      <= '0;
      full_q      <= 1'b0;
      last_q      <= '0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      rise_q      <= '0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_done  <= done_d;
      frame_abort <= abort_d;
      underrun    <= start & ~full_q;
      // a push in the start cycle refills holding for the next frame
      if (start && full_q) begin
        full_q <= 1'b0;
      end else if (push) begin
        full_q <= 1'b1;
        hold_q <= tx_data;
      end
      if (start) begin
        shreg_q <= FRAME_BITS'(word);
        last_q  <= word;
        cnt_q   <= CW'(1);
        rise_q  <= '0;
      end
      if (shift) begin
        if (cnt_q < LAST) begin
          shreg_q <= shreg_q << 1;
          cnt_q   <= cnt_q + CW'(1);
        end else begin
          shreg_q <= '0;
        end
      end
      if (rise && (rise_q < LAST)) begin
        rise_q <= rise_q + CW'(1);
      end
      if (finish) begin
        shreg_q <= '0;
      end
    end
  end

endmodule
